// File: rtl/regfile_pkg.sv
// Constants and types shared by the register file and its writeback controller.
package regfile_pkg;
  localparam int REG_AW   = 5;
  localparam int REG_DW   = 32;
  localparam int NUM_REGS = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } wb_state_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_AW-1:0] a);
    reg_onehot    = '0;
    reg_onehot[a] = 1'b1;
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// Writeback request FIFO; exposes every slot's address so pending writes can be decoded.
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [AW-1:0]            push_addr,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [AW-1:0]            head_addr,
  output logic [DW-1:0]            head_data,
  output logic                     full,
  output logic                     empty,
  output logic [DEPTH-1:0]         entry_valid,
  output logic [DEPTH-1:0][AW-1:0] entry_addr
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] count;
  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [IW-1:0] offset;
  logic          do_push;
  logic          do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[IW] != rd_ptr[IW]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head_addr = addr_mem[rd_ptr[IW-1:0]];
  assign head_data = data_mem[rd_ptr[IW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: slots outside the valid window are masked.
  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_mem[wr_ptr[IW-1:0]] <= push_addr;
      data_mem[wr_ptr[IW-1:0]] <= push_data;
    end
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    offset      = '0;
    entry_valid = '0;
    entry_addr  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset         = IW'(i) - rd_ptr[IW-1:0];
      entry_valid[i] = ({1'b0, offset} < count);
      entry_addr[i]  = addr_mem[i];
    end
  end
endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback controller: queues register writes and replays each one as a
// setup/strobe/hold sequence on the register file's edge-triggered write port.
module regfile_wb_ctrl
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_valid,
  output logic                wb_ready,
  input  logic [AW-1:0]       wb_addr,
  input  logic [DW-1:0]       wb_data,
  output logic [AW-1:0]       A3,
  output logic [DW-1:0]       WD3,
  output logic                WE3,
  output logic [NUM_REGS-1:0] pending,
  output logic                idle,
  output wb_state_t           state
);
  // Handshake: a request transfers on a clock edge where wb_valid && wb_ready.
  // wb_ready is !full only, so it never depends on a same-cycle pop.

  wb_state_t               state_next;
  logic                    push;
  logic                    pop;
  logic                    full;
  logic                    empty;
  logic [AW-1:0]           head_addr;
  logic [DW-1:0]           head_data;
  logic [DEPTH-1:0]        entry_valid;
  logic [DEPTH-1:0][AW-1:0] entry_addr;

  assign wb_ready = !full;
  // Writes to register 0 are acknowledged and dropped.
  assign push     = wb_valid && wb_ready && (wb_addr != '0);
  assign idle     = empty && (state == IDLE);

  wb_fifo #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .DW   (DW)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_addr  (wb_addr),
    .push_data  (wb_data),
    .pop        (pop),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .full       (full),
    .empty      (empty),
    .entry_valid(entry_valid),
    .entry_addr (entry_addr)
  );

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP:  state_next = STROBE;
      STROBE: state_next = HOLD;
      HOLD: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = SETUP;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A3/WD3 load only when entering SETUP, so they are stable across the WE3 pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      A3    <= '0;
      WD3   <= '0;
      WE3   <= 1'b0;
    end else begin
      state <= state_next;
      WE3   <= (state_next == STROBE);
      if (pop) begin
        A3  <= head_addr;
        WD3 <= head_data;
      end
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) pending = pending | reg_onehot(entry_addr[i]);
    end
    if (state != IDLE) pending = pending | reg_onehot(A3);
    pending[0] = 1'b0;
  end
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Bench for regfile_wb_ctrl: timeline reference model plus a write-order scoreboard.
module tb_regfile_wb_ctrl;
  import regfile_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic        WE3;
  logic [31:0] pending;
  logic        idle;
  wb_state_t   state;

  regfile_wb_ctrl #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .wb_valid(wb_valid),
    .wb_ready(wb_ready),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .A3      (A3),
    .WD3     (WD3),
    .WE3     (WE3),
    .pending (pending),
    .idle    (idle),
    .state   (state)
  );

  always #5 clk = ~clk;

  // Each accepted write: k = accept edge, p = edge it is popped into A3/WD3.
  // p = max(k+1, previous p + 3); WE3 is high in cycle p+1; busy until edge p+3.
  typedef struct {
    int          k;
    int          p;
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t         wq[$];
  logic [36:0] exp_q[$];
  logic [31:0] rf[32];
  logic [31:0] exp_rf[32];
  int          cyc;
  int          last_p;
  int          errors;
  int          checks;
  bit          model_ready;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Register file stand-in plus in-order write scoreboard.
  always @(posedge WE3) begin
    logic [36:0] e;
    rf[A3] = WD3;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL we3_unexpected observed=%0h expected=none", {A3, WD3});
    end else begin
      e = exp_q.pop_front();
      assert ({A3, WD3} === e)
      else begin
        errors++;
        $error("FAIL write_order observed=%0h expected=%0h", {A3, WD3}, e);
      end
    end
  end

  task automatic check_cycle();
    int          occ;
    int          best;
    bit          we;
    bit          busy;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic [31:0] ep;
    wb_state_t   es;
    occ = 0; best = -1000; we = 0; busy = 0; ea = '0; ed = '0; ep = '0; es = IDLE;
    foreach (wq[j]) begin
      if (wq[j].k <= cyc && cyc < wq[j].p) occ++;
      if (cyc == wq[j].p)     es = SETUP;
      if (cyc == wq[j].p + 1) begin
        es = STROBE;
        we = 1;
        exp_rf[wq[j].a] = wq[j].d;
      end
      if (cyc == wq[j].p + 2) es = HOLD;
      if (wq[j].p <= cyc && wq[j].p > best) begin
        best = wq[j].p;
        ea   = wq[j].a;
        ed   = wq[j].d;
      end
      if (wq[j].k <= cyc && cyc < wq[j].p + 3) begin
        busy      = 1;
        ep[wq[j].a] = 1'b1;
      end
    end
    model_ready = (occ < DEPTH);
    chk("wb_ready", wb_ready, model_ready);
    chk("we3", WE3, we);
    chk("a3", A3, ea);
    chk("wd3", WD3, ed);
    chk("pending", pending, ep);
    chk("idle", idle, !busy);
    chk("state", state, es);
  endtask

  task automatic step(input bit v, input logic [4:0] a, input logic [31:0] d, output bit acc);
    wr_t w;
    check_cycle();
    wb_valid = v;
    wb_addr  = a;
    wb_data  = d;
    acc      = v && model_ready;
    if (acc && a != 5'd0) begin
      w.k = cyc + 1;
      w.p = (cyc + 2 > last_p + 3) ? cyc + 2 : last_p + 3;
      w.a = a;
      w.d = d;
      last_p = w.p;
      wq.push_back(w);
      exp_q.push_back({a, d});
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    wb_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, acc);
  endtask

  task automatic send(input logic [4:0] a, input logic [31:0] d);
    bit acc;
    int tries;
    acc = 0;
    tries = 0;
    while (!acc && tries < 64) begin
      step(1'b1, a, d, acc);
      tries++;
    end
    if (!acc) chk("send_timeout", tries, 0);
  endtask

  initial begin
    int target;
    int tries;
    bit acc;
    errors = 0; checks = 0; last_p = -100; cyc = 0;
    for (int r = 0; r < 32; r++) begin
      rf[r]     = '0;
      exp_rf[r] = '0;
    end
    rst = 1'b1; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    idle_cycles(2);

    // Single write, then register 0 write that must vanish.
    send(5'd5, 32'hDEADBEEF);
    idle_cycles(6);
    chk("rf5_single", rf[5], 32'hDEADBEEF);
    send(5'd0, 32'h1234);
    idle_cycles(4);

    // Five back-to-back writes into a four-deep queue.
    for (int r = 1; r <= 5; r++) send(5'(r), 32'h100 + 32'(r));
    idle_cycles(20);

    // Same register twice; last value must win.
    send(5'd7, 32'hA);
    send(5'd7, 32'hB);
    idle_cycles(10);
    chk("rf7_last_wins", rf[7], 32'hB);

    // Reset while the first of three writes is strobing.
    send(5'd10, 32'hAAAA0010);
    send(5'd11, 32'hAAAA0011);
    send(5'd12, 32'hAAAA0012);
    target = wq[wq.size() - 3].p + 1;
    tries = 0;
    while (cyc < target && tries < 20) begin
      step(1'b0, 5'd0, 32'd0, acc);
      tries++;
    end
    check_cycle();
    rst = 1'b1;
    #1;
    chk("rst_we3", WE3, 1'b0);
    chk("rst_a3", A3, 5'd0);
    chk("rst_wd3", WD3, 32'd0);
    chk("rst_ready", wb_ready, 1'b1);
    chk("rst_pending", pending, 32'd0);
    chk("rst_idle", idle, 1'b1);
    wq.delete();
    exp_q.delete();
    last_p = -100;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(10);

    // Twelve random writes with random gaps to exercise pointer wrap.
    for (int i = 0; i < 12; i++) begin
      send(5'($urandom_range(1, 31)), $urandom);
      idle_cycles($urandom_range(0, 2));
    end
    idle_cycles(40);

    // Free-running random traffic including register 0.
    for (int i = 0; i < 40; i++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, acc);
    end
    idle_cycles(60);

    for (int r = 0; r < 32; r++) chk($sformatf("rf%0d", r), rf[r], exp_rf[r]);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
